// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ctrl_pkg
//  Description : Shared types and address-width helpers for the instruction
//                memory load/fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_ctrl_pkg;

    // Default memory depth in words and the address width it implies
    localparam int MEM_SIZE_DEF = 32;
    localparam int AW           = $clog2(MEM_SIZE_DEF);

    // Controller operating modes
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    // Word-address width for a given memory depth (depth is a power of two)
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pc_gen
//  Description : Fetch program counter. Advances by one word per cycle with
//                natural wrap at the memory depth, holds on stall and loads
//                the low address bits of a branch target on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_pc_gen
    import imem_ctrl_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int ADDR_W = AW
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              branch,
    input  logic              stall,
    input  logic [SIZE-1:0]   branch_target,
    output logic [ADDR_W-1:0] fetch_pc
);

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;

    // Only the low address bits of a branch target select a word; the rest
    // are deliberately dropped so the target wraps modulo the memory depth.
    if (SIZE > ADDR_W) begin : g_tgt_hi
        logic unused_tgt_hi;
        assign unused_tgt_hi = ^branch_target[SIZE-1:ADDR_W];
    end

    // Next PC: clear outside RUN, then redirect, then hold on stall, else +1
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (clear) begin
            fetch_pc_d = '0;
        end else if (branch) begin
            fetch_pc_d = branch_target[ADDR_W-1:0];
        end else if (!stall) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    // PC register with synchronous active-low reset
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            fetch_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign fetch_pc = fetch_pc_q;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Owns the single InstructionMemory port. Loads a program from
//                a valid/ready word stream, then fetches instructions for the
//                decode stage with stall and branch-redirect handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic            clka,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            run_start,
    input  logic            load_valid,
    input  logic [SIZE-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    output logic            load_err,
    output logic            running,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [SIZE-1:0] branch_target,
    output logic            instr_valid,
    output logic [SIZE-1:0] instr_out,
    output logic [SIZE-1:0] pc_out,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_din,
    input  logic [SIZE-1:0] mem_dout
);

    localparam int                ADDR_W   = addr_width(MEM_SIZE);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_SIZE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic              load_err_q, load_err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [SIZE-1:0]   mem_din_q, mem_din_d;
    logic              instr_valid_q, instr_valid_d;
    logic [SIZE-1:0]   instr_out_q, instr_out_d;
    logic [SIZE-1:0]   pc_out_q, pc_out_d;

    logic [ADDR_W-1:0] fetch_pc;
    logic              in_run;
    logic              accept;
    logic              last_word;
    logic              enter_load;
    logic              pc_branch;

    assign in_run     = (state_q == ST_RUN);
    assign accept     = (state_q == ST_LOAD) && load_valid;
    assign last_word  = load_last || (load_ptr_q == LAST_PTR);
    assign enter_load = (state_q != ST_LOAD) && (state_d == ST_LOAD);
    // A load request in RUN outranks the branch, so the redirect is dropped
    assign pc_branch  = in_run && branch_taken && !load_start;

    imem_pc_gen #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_pc_gen (
        .clka          (clka),
        .rst_n         (rst_n),
        .clear         (!in_run),
        .branch        (pc_branch),
        .stall         (stall),
        .branch_target (branch_target),
        .fetch_pc      (fetch_pc)
    );

    // Mode sequencing: IDLE -> LOAD -> DRAIN -> RUN, load request re-enters LOAD
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (accept && last_word) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = load_start ? ST_LOAD : ST_RUN;
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Load pointer, overflow flag and the one-cycle-delayed memory write
    always_comb begin
        load_ptr_d = load_ptr_q;
        load_err_d = load_err_q;
        mem_we_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        mem_din_d  = mem_din_q;
        if (enter_load) begin
            load_ptr_d = '0;
            load_err_d = 1'b0;
        end else if (accept) begin
            load_ptr_d = load_ptr_q + ADDR_W'(1);
            if ((load_ptr_q == LAST_PTR) && !load_last) begin
                load_err_d = 1'b1;
            end
        end
        if (accept) begin
            mem_we_d  = 1'b1;
            wr_addr_d = load_ptr_q;
            mem_din_d = load_data;
        end
    end

    // Fetch output register: capture read data, bubble on redirect, hold on stall
    always_comb begin
        instr_valid_d = 1'b0;
        instr_out_d   = instr_out_q;
        pc_out_d      = pc_out_q;
        if (in_run && !load_start && !branch_taken) begin
            if (stall) begin
                instr_valid_d = instr_valid_q;
            end else begin
                instr_valid_d = 1'b1;
                pc_out_d      = SIZE'(fetch_pc);
                instr_out_d   = mem_dout;
            end
        end
    end

    // All controller state, synchronous active-low reset
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            load_ptr_q    <= '0;
            load_err_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            wr_addr_q     <= '0;
            mem_din_q     <= '0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            pc_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            load_err_q    <= load_err_d;
            mem_we_q      <= mem_we_d;
            wr_addr_q     <= wr_addr_d;
            mem_din_q     <= mem_din_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            pc_out_q      <= pc_out_d;
        end
    end

    // The port carries the fetch PC in RUN and the pending write address otherwise
    assign mem_addr    = in_run ? SIZE'(fetch_pc) : SIZE'(wr_addr_q);
    assign mem_we      = mem_we_q;
    assign mem_din     = mem_din_q;
    assign load_ready  = (state_q == ST_LOAD);
    assign running     = in_run;
    assign load_err    = load_err_q;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign pc_out      = pc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_ctrl
//  Description : Self-checking bench for imem_fetch_ctrl with a behavioural
//                memory and a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int SIZE     = 32;
    localparam int MEM_SIZE = 32;
    localparam int AWB      = $clog2(MEM_SIZE);
    localparam int M_IDLE   = 0;
    localparam int M_LOAD   = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_RUN    = 3;

    logic            clka = 1'b0;
    logic            rst_n = 1'b0;
    logic            load_start = 1'b0;
    logic            run_start = 1'b0;
    logic            load_valid = 1'b0;
    logic [SIZE-1:0] load_data = '0;
    logic            load_last = 1'b0;
    logic            stall = 1'b0;
    logic            branch_taken = 1'b0;
    logic [SIZE-1:0] branch_target = '0;
    logic            load_ready, load_err, running, instr_valid, mem_we;
    logic [SIZE-1:0] instr_out, pc_out, mem_addr, mem_din, mem_dout;

    logic [SIZE-1:0] mem [MEM_SIZE];
    logic [SIZE-1:0] em  [MEM_SIZE];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int              m_mode, m_ptr, m_pc, m_waddr, m_pcout;
    logic            m_err, m_wpend, m_valid;
    logic [SIZE-1:0] m_wdata, m_instr;

    always #5 clka = ~clka;

    imem_fetch_ctrl #(
        .SIZE     (SIZE),
        .MEM_SIZE (MEM_SIZE)
    ) dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .run_start     (run_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_err      (load_err),
        .running       (running),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout)
    );

    function automatic logic [SIZE-1:0] init_word(input int i);
        return 32'h5EED_0000 + SIZE'(i) * 32'h0001_0101;
    endfunction

    task automatic check(input string name, input logic [SIZE-1:0] act,
                         input logic [SIZE-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Instruction memory: read data follows the address, writes on the edge
    assign mem_dout = mem[mem_addr[AWB-1:0]];
    initial begin : memory
        for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_word(i);
        forever begin
            @(posedge clka);
            if (mem_we) mem[mem_addr[AWB-1:0]] <= mem_din;
        end
    end

    // Reference model stepped on each edge, outputs compared 1 time unit later
    initial begin : model_check
        for (int i = 0; i < MEM_SIZE; i++) em[i] = init_word(i);
        m_mode = M_IDLE; m_ptr = 0; m_pc = 0; m_waddr = 0; m_pcout = 0;
        m_err = 0; m_wpend = 0; m_valid = 0; m_wdata = '0; m_instr = '0;
        forever begin
            @(posedge clka);
            if (m_wpend) em[m_waddr] = m_wdata;
            m_wpend = 0;
            if (!rst_n) begin
                m_mode = M_IDLE; m_ptr = 0; m_pc = 0; m_err = 0; m_waddr = 0;
                m_valid = 0; m_pcout = 0; m_instr = '0; m_wdata = '0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (load_start) begin
                            m_mode = M_LOAD; m_ptr = 0; m_err = 0;
                        end else if (run_start) begin
                            m_mode = M_RUN; m_pc = 0;
                        end
                    end
                    M_LOAD: begin
                        if (load_valid) begin
                            m_wpend = 1; m_waddr = m_ptr; m_wdata = load_data;
                            if (load_last || m_ptr == MEM_SIZE - 1) begin
                                m_mode = M_DRAIN;
                                if (!load_last) m_err = 1;
                            end
                            m_ptr++;
                        end
                    end
                    M_DRAIN: begin
                        if (load_start) begin
                            m_mode = M_LOAD; m_ptr = 0; m_err = 0;
                        end else begin
                            m_mode = M_RUN; m_pc = 0;
                        end
                    end
                    default: begin
                        if (load_start) begin
                            m_mode = M_LOAD; m_ptr = 0; m_err = 0; m_valid = 0;
                        end else if (branch_taken) begin
                            m_pc = int'(branch_target % MEM_SIZE); m_valid = 0;
                        end else if (!stall) begin
                            m_valid = 1; m_pcout = m_pc; m_instr = em[m_pc];
                            m_pc = (m_pc + 1) % MEM_SIZE;
                        end
                    end
                endcase
            end
            #1;
            check("load_ready", load_ready, m_mode == M_LOAD);
            check("running", running, m_mode == M_RUN);
            check("load_err", load_err, m_err);
            check("mem_we", mem_we, m_wpend);
            if (m_wpend) begin
                check("wr_addr", mem_addr, m_waddr);
                check("wr_data", mem_din, m_wdata);
            end
            if (m_mode == M_RUN) check("fetch_addr", mem_addr, m_pc);
            check("instr_valid", instr_valid, m_valid);
            if (m_valid) begin
                check("pc_out", pc_out, m_pcout);
                check("instr_out", instr_out, m_instr);
            end
        end
    end

    task automatic wait_running();
        int n = 0;
        while (running !== 1'b1 && n < 20) begin
            @(negedge clka);
            n++;
        end
        check("wait_running", running, 1);
    endtask

    // Directed scenarios with literal expectations, then randomized traffic
    initial begin : stim
        repeat (3) @(negedge clka);
        check("rst_load_ready", load_ready, 0);
        check("rst_running", running, 0);
        check("rst_load_err", load_err, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        rst_n = 1;

        // four-word program, then fetch with a 3-cycle stall at pc 2
        load_start = 1; @(negedge clka); load_start = 0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_data = 32'hA000_0000 + i; load_last = (i == 3);
            @(negedge clka);
        end
        load_valid = 0; load_last = 0;
        check("drain_we", mem_we, 1);
        check("drain_addr", mem_addr, 3);
        wait_running();
        check("run_entry_addr", mem_addr, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            check("seq_pc", pc_out, i);
            check("seq_instr", instr_out, 32'hA000_0000 + i);
        end
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clka);
            check("stall_pc", pc_out, 2);
            check("stall_instr", instr_out, 32'hA000_0002);
            check("stall_valid", instr_valid, 1);
        end
        stall = 0;
        @(negedge clka);
        check("release_pc", pc_out, 3);
        check("release_instr", instr_out, 32'hA000_0003);

        // branch to 0x25 wraps to word 5 after one bubble
        branch_taken = 1; branch_target = 32'h25;
        @(negedge clka);
        branch_taken = 0;
        check("bubble_valid", instr_valid, 0);
        check("branch_addr", mem_addr, 5);
        @(negedge clka);
        check("branch_valid", instr_valid, 1);
        check("branch_pc", pc_out, 5);
        check("branch_instr", instr_out, init_word(5));

        // load request beats a simultaneous branch
        load_start = 1; branch_taken = 1; branch_target = 32'h7;
        @(negedge clka);
        load_start = 0; branch_taken = 0;
        check("prio_load_ready", load_ready, 1);
        check("prio_running", running, 0);
        check("prio_valid", instr_valid, 0);

        // gapped loader stream
        for (int k = 0; k < 8; k++) begin
            load_valid = (k % 2 == 0); load_data = 32'hB000_0000 + k / 2;
            load_last = (k == 6);
            @(negedge clka);
        end
        load_valid = 0; load_last = 0;
        wait_running();
        for (int i = 0; i < 4; i++) begin
            @(negedge clka);
            check("gap_pc", pc_out, i);
            check("gap_instr", instr_out, 32'hB000_0000 + i);
        end

        // overflow: 32 words without a last marker
        load_start = 1; @(negedge clka); load_start = 0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            load_valid = 1; load_data = 32'hD000_0000 + i; load_last = 0;
            @(negedge clka);
        end
        load_valid = 0;
        check("ovf_err", load_err, 1);
        check("ovf_we", mem_we, 1);
        check("ovf_addr", mem_addr, 31);
        check("ovf_din", mem_din, 32'hD000_001F);
        wait_running();

        // reset in the middle of a load keeps the words already written
        load_start = 1; @(negedge clka); load_start = 0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1; load_data = 32'hC000_0000 + i; @(negedge clka);
        end
        load_valid = 0;
        repeat (2) @(negedge clka);
        rst_n = 0;
        repeat (2) @(negedge clka);
        rst_n = 1;
        check("mid_rst_ready", load_ready, 0);
        check("mid_rst_running", running, 0);
        run_start = 1; @(negedge clka); run_start = 0;
        check("mid_rst_run", running, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            check("mid_rst_pc", pc_out, i);
            check("mid_rst_instr", instr_out, (i < 2) ? 32'hC000_0000 + i : 32'hD000_0002);
        end

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            load_start    = ($urandom_range(0, 49) == 0);
            run_start     = ($urandom_range(0, 19) == 0);
            load_valid    = $urandom_range(0, 1) == 1;
            load_last     = ($urandom_range(0, 11) == 0);
            load_data     = $urandom;
            stall         = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = $urandom;
            @(negedge clka);
        end
        rst_n = 1; load_start = 0; run_start = 0; load_valid = 0;
        load_last = 0; stall = 0; branch_taken = 0;
        repeat (3) @(negedge clka);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
